// File: rtl/mul_share_seq.sv
// Shared sequential shift-add multiplier serving two valid/ready requesters.
// A round-robin arbiter picks one operand pair; the product returns tagged with its requester ID.
module mul_share_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_result,
    input  logic               rsp_ready,
    output logic               busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic               last_grant;
    logic               grant;
    logic               accept;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CNT_W-1:0]   cnt;

    // One iteration: add the partial product into the upper half, keep the carry, shift right.
    function automatic logic [2*WIDTH-1:0] add_shift(input logic [2*WIDTH-1:0] acc_in,
                                                     input logic [WIDTH-1:0]   a,
                                                     input logic               b0);
        logic [WIDTH:0]   sum;
        logic [2*WIDTH:0] ext;
        sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, (b0 ? a : {WIDTH{1'b0}})};
        ext = {sum, acc_in[WIDTH-1:0]};
        ext = ext >> 1;
        return ext[2*WIDTH-1:0];
    endfunction

    assign acc_next = add_shift(acc, a_reg, b_reg[0]);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            acc        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= grant ? req1_a : req0_a;
                        b_reg      <= grant ? req1_b : req0_b;
                        acc        <= '0;
                        cnt        <= '0;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        busy       <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        rsp_result <= acc_next;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_seq.sv
// Scoreboard bench for mul_share_seq: expected products are queued at request accept
// and a monitor pops and compares them at every response handshake.
module tb_mul_share_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, rsp_ready, busy;
    logic [7:0] rsp_result;

    int         n_vec = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];
    bit         stall_en = 1'b0;

    always #5 clk = ~clk;

    mul_share_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp, input bit push);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                got = 1'b1;
                if (push) exp_q.push_back({id, exp});
            end
        end
        if (!got) timeout("accept");
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !rsp_valid) ok = 1'b1;
        end
        if (!ok) timeout("drain");
    endtask

    initial begin
        int lat;
        bit seen;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;

        fork
            forever begin
                logic [8:0] e;
                @(negedge clk);
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got id %0d result 0x%0h, want no response",
                                 rsp_id, rsp_result);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id_result", {7'b0, rsp_id, rsp_result}, {7'b0, e});
                    end
                end
            end
            forever begin
                @(posedge clk); #1;
                if (stall_en) rsp_ready = ($urandom_range(0, 3) != 0);
            end
        join_none

        // Reset values, with a request pending during reset
        req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("reset_rsp_id", 16'(rsp_id), 16'h0);
        chk("reset_rsp_result", 16'(rsp_result), 16'h0);
        chk("reset_busy", 16'(busy), 16'h0);
        chk("reset_req0_ready", 16'(req0_ready), 16'h0);
        req0_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Single request 3x5 with latency check
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
        @(negedge clk);
        chk("t1_req0_ready", 16'(req0_ready), 16'h1);
        if (req0_ready) exp_q.push_back({1'b0, 8'h0F});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_ready_drop", 16'(req0_ready), 16'h0);
        chk("t1_busy", 16'(busy), 16'h1);
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) seen = 1'b1;
        end
        chk("t1_latency", 16'(lat), 16'd4);
        @(negedge clk);
        chk("t1_busy_after", 16'(busy), 16'h0);

        // Corner operands
        issue(1'b0, 4'd15, 4'd15, 8'hE1, 1'b1);
        issue(1'b1, 4'd0,  4'd9,  8'h00, 1'b1);
        issue(1'b0, 4'd9,  4'd0,  8'h00, 1'b1);
        issue(1'b1, 4'd1,  4'd15, 8'h0F, 1'b1);
        issue(1'b0, 4'd8,  4'd8,  8'h40, 1'b1);
        wait_idle();

        // Simultaneous requests after a fresh reset; round-robin order
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        fork
            issue(1'b0, 4'd2, 4'd3, 8'd6, 1'b1);
            issue(1'b1, 4'd4, 4'd4, 8'd16, 1'b1);
        join
        wait_idle();
        fork
            issue(1'b1, 4'd5, 4'd5, 8'd25, 1'b1);
            issue(1'b0, 4'd7, 4'd2, 8'd14, 1'b1);
        join
        wait_idle();

        // Backpressure in DONE
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1'b0, 4'd7, 4'd8, 8'h38, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        if (!seen) timeout("bp_rsp_valid");
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 16'(rsp_valid), 16'h1);
            chk("bp_rsp_result", 16'(rsp_result), 16'h38);
            chk("bp_rsp_id", 16'(rsp_id), 16'h0);
            chk("bp_req1_ready", 16'(req1_ready), 16'h0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_req1_ready_in_done", 16'(req1_ready), 16'h0);
        @(negedge clk);
        chk("bp_req1_accept", 16'(req1_ready), 16'h1);
        if (req1_ready) exp_q.push_back({1'b1, 8'd27});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_idle();

        // Asynchronous reset during CALC discards the product
        issue(1'b1, 4'd6, 4'd7, 8'd42, 1'b0);
        @(posedge clk); #2;
        chk("rst_busy_before", 16'(busy), 16'h1);
        chk("rst_id_before", 16'(rsp_id), 16'h1);
        rst_n = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_rsp_id", 16'(rsp_id), 16'h0);
        chk("rst_rsp_result", 16'(rsp_result), 16'h0);
        chk("rst_req1_ready", 16'(req1_ready), 16'h0);
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_no_rsp", 16'(rsp_valid), 16'h0);
        issue(1'b1, 4'd6, 4'd7, 8'd42, 1'b1);
        wait_idle();

        // All operand pairs on both requesters, random gaps and stalls
        stall_en = 1'b1;
        fork
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    issue(1'b0, 4'(a), 4'(b), 8'(a * b), 1'b1);
                end
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    issue(1'b1, 4'(a), 4'(b), 8'(a * b), 1'b1);
                end
        join
        stall_en = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
